// File: rtl/lsu_pkg.sv
// Shared core definitions: load/store funct3 codes, lsu state encoding and
// writeback record widths. The funct3 codes are also used by the decoder.
package lsu_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned WB_RD_W   = 5;
   localparam int unsigned WB_DATA_W = 32;
   localparam int unsigned CNT_W     = 16;

   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} lsu_state_e;

   typedef enum logic [1:0] {SzByte, SzHalf, SzWord} ls_size_e;

   // Access size for a funct3; reserved codes behave as word accesses.
   function automatic ls_size_e ls_size(input logic [2:0] funct3);
      ls_size_e sz;
      case (funct3)
         LS_B, LS_BU: sz = SzByte;
         LS_H, LS_HU: sz = SzHalf;
         LS_W:        sz = SzWord;
         default:     sz = SzWord;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory port: request/grant for the command, rvalid for read data or
// store acknowledge.
interface lsu_if;
   import lsu_pkg::*;

   logic            req;
   logic            we;
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] wdata;
   logic [3:0]      wstrb;
   logic            gnt;
   logic            rvalid;
   logic [XLEN-1:0] rdata;

   modport master (
      output req, we, addr, wdata, wstrb,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata, wstrb,
      output gnt, rvalid, rdata
   );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane handling for the lsu: store data replication and strobes, the
// misalignment check, and load lane extraction with sign/zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]      off,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] wdata_lane,
   output logic [3:0]      wstrb,
   output logic            misalign,
   input  logic [1:0]      ld_off,
   input  logic [2:0]      ld_funct3,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] ld_data
);

   ls_size_e        st_sz;
   ls_size_e        ld_sz;
   logic [XLEN-1:0] shifted;
   logic            ld_unsigned;

   // Store side: replicate the datum across lanes, strobe the addressed lanes.
   always_comb begin
      st_sz      = ls_size(funct3);
      wdata_lane = wdata;
      wstrb      = 4'b1111;
      misalign   = 1'b0;
      case (st_sz)
         SzByte: begin
            wdata_lane = {4{wdata[7:0]}};
            wstrb      = 4'b0001 << off;
         end
         SzHalf: begin
            wdata_lane = {2{wdata[15:0]}};
            wstrb      = 4'b0011 << off;
            misalign   = off[0];
         end
         default: begin
            misalign = (off != 2'b00);
         end
      endcase
   end

   // Load side: bring the addressed lane down to bit 0, then extend.
   always_comb begin
      ld_sz       = ls_size(ld_funct3);
      ld_unsigned = ld_funct3[2];
      shifted     = rdata >> {ld_off, 3'b000};
      ld_data     = rdata;
      case (ld_sz)
         SzByte:  ld_data = ld_unsigned ? {24'b0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
         SzHalf:  ld_data = ld_unsigned ? {16'b0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
         default: ld_data = rdata;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one instruction from execute, performs at most one
// data-memory access, and emits one writeback record per instruction.
module lsu
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ex_valid,
   output logic                 ex_ready,
   input  logic                 ex_load,
   input  logic                 ex_store,
   input  logic [2:0]           ex_funct3,
   input  logic [XLEN-1:0]      ex_res,
   input  logic [XLEN-1:0]      ex_wdata,
   input  logic [WB_RD_W-1:0]   ex_rd,
   lsu_if.master                mem,
   output logic                 wb_valid,
   output logic [WB_RD_W-1:0]   wb_rd,
   output logic [WB_DATA_W-1:0] wb_data,
   output logic                 err_misalign,
   output logic                 err_bus
);

   lsu_state_e           state_q;
   logic                 ex_ready_q;
   logic                 req_q;
   logic                 we_q;
   logic [XLEN-1:0]      addr_q;
   logic [XLEN-1:0]      wdata_q;
   logic [3:0]           wstrb_q;
   logic                 wb_valid_q;
   logic [WB_RD_W-1:0]   wb_rd_q;
   logic [WB_DATA_W-1:0] wb_data_q;
   logic                 err_mis_q;
   logic                 err_bus_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 ld_q;
   logic [1:0]           off_q;
   logic [2:0]           f3_q;
   logic [WB_RD_W-1:0]   rd_q;

   logic                 is_mem;
   logic [XLEN-1:0]      st_wdata;
   logic [3:0]           st_wstrb;
   logic                 misalign;
   logic [XLEN-1:0]      ld_data;
   logic [CNT_W:0]       cnt_nxt;
   logic                 cnt_hit;
   logic [WB_RD_W-1:0]   rsp_rd;
   logic [WB_DATA_W-1:0] rsp_data;

   lsu_align u_align (
      .off        (ex_res[1:0]),
      .funct3     (ex_funct3),
      .wdata      (ex_wdata),
      .wdata_lane (st_wdata),
      .wstrb      (st_wstrb),
      .misalign   (misalign),
      .ld_off     (off_q),
      .ld_funct3  (f3_q),
      .rdata      (mem.rdata),
      .ld_data    (ld_data)
   );

   // Decode of the incoming op, timeout compare and response writeback values.
   always_comb begin
      // load+store together is illegal and degrades to a pass-through
      is_mem   = ex_load ^ ex_store;
      cnt_nxt  = {1'b0, cnt_q} + 17'd1;
      cnt_hit  = (cnt_nxt == 17'(TIMEOUT));
      rsp_rd   = ld_q ? rd_q : '0;
      rsp_data = ld_q ? ld_data : '0;
   end

   // Control FSM with all outputs registered; pulses default low each cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         ex_ready_q <= 1'b1;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         err_mis_q  <= 1'b0;
         err_bus_q  <= 1'b0;
         cnt_q      <= '0;
         ld_q       <= 1'b0;
         off_q      <= '0;
         f3_q       <= '0;
         rd_q       <= '0;
      end else begin
         wb_valid_q <= 1'b0;
         err_mis_q  <= 1'b0;
         err_bus_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (ex_valid) begin
                  ex_ready_q <= 1'b0;
                  state_q    <= StDone;
                  if (!is_mem) begin
                     wb_valid_q <= 1'b1;
                     wb_rd_q    <= ex_rd;
                     wb_data_q  <= ex_res;
                  end else if (misalign) begin
                     wb_valid_q <= 1'b1;
                     wb_rd_q    <= '0;
                     wb_data_q  <= '0;
                     err_mis_q  <= 1'b1;
                  end else begin
                     state_q <= StReq;
                     req_q   <= 1'b1;
                     we_q    <= ex_store;
                     addr_q  <= {ex_res[XLEN-1:2], 2'b00};
                     wdata_q <= st_wdata;
                     wstrb_q <= ex_store ? st_wstrb : 4'b0000;
                     ld_q    <= ex_load;
                     off_q   <= ex_res[1:0];
                     f3_q    <= ex_funct3;
                     rd_q    <= ex_rd;
                     cnt_q   <= '0;
                  end
               end
            end
            StReq: begin
               // a grant on the timeout cycle still completes the handshake
               if (mem.gnt && mem.rvalid) begin
                  req_q      <= 1'b0;
                  state_q    <= StDone;
                  wb_valid_q <= 1'b1;
                  wb_rd_q    <= rsp_rd;
                  wb_data_q  <= rsp_data;
               end else if (mem.gnt) begin
                  req_q   <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= StWait;
               end else if (cnt_hit) begin
                  req_q      <= 1'b0;
                  state_q    <= StDone;
                  wb_valid_q <= 1'b1;
                  wb_rd_q    <= '0;
                  wb_data_q  <= '0;
                  err_bus_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_nxt[CNT_W-1:0];
               end
            end
            StWait: begin
               if (mem.rvalid) begin
                  state_q    <= StDone;
                  wb_valid_q <= 1'b1;
                  wb_rd_q    <= rsp_rd;
                  wb_data_q  <= rsp_data;
               end else if (cnt_hit) begin
                  state_q    <= StDone;
                  wb_valid_q <= 1'b1;
                  wb_rd_q    <= '0;
                  wb_data_q  <= '0;
                  err_bus_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_nxt[CNT_W-1:0];
               end
            end
            StDone: begin
               state_q    <= StIdle;
               ex_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign ex_ready     = ex_ready_q;
   assign mem.req      = req_q;
   assign mem.we       = we_q;
   assign mem.addr     = addr_q;
   assign mem.wdata    = wdata_q;
   assign mem.wstrb    = wstrb_q;
   assign wb_valid     = wb_valid_q;
   assign wb_rd        = wb_rd_q;
   assign wb_data      = wb_data_q;
   assign err_misalign = err_mis_q;
   assign err_bus      = err_bus_q;

endmodule
